host_console: RTL and testbench

Host-side (initiator) counterpart of the per-device console sequencer. It consumes the device link announcement, then issues the command packets: device index (BAG_DIDX), parameter (BAG_DPARAM) and conversion index (BAG_DDIDX). For each command it waits for the matching reply (BAG_DTYPE, BAG_DTEMP, BAG_DATA0), latches the reply payload and reports it downstream. It sits between host control logic and the host-side com packet transmitter/receiver.

---
 rtl/host_console.sv | 330 +++++++++++++++++++++++++++++++++
 tb/tb_host_console.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/host_console.sv
`default_nettype none
// ============================================================================
// Module   : host_console
// Purpose  : Host-side console sequencer. Waits for the device link
//            announcement, then issues the device-index and parameter command
//            packets, collecting the type and temperature replies. Afterwards,
//            while 'run' is high, it issues conversion-index packets back to
//            back and reports each DATA0 reply downstream. Every send or wait
//            phase is guarded by a timeout. Any unexpected reply type ends in
//            an error state, which can be retried with 'start'.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   start, run                sequence start/retry pulse, conversion enable
//   cfg_didx, cfg_freq        device index / ADC frequency, latched on start
//   fs_com_send, fd_com_send  transmit request / transmitter done
//   send_btype, send_param    packet type and payload nibble to transmit
//   fs_com_read, fd_com_read  receiver holds packet / packet acknowledged
//   read_btype/type/temp/stat received packet fields
//   link_ok                   DLINK seen
//   dev_type, dev_temp        committed device type / temperature
//   dev_stat, data_vld        last DATA0 status, one-cycle report strobe
//   conv_cnt                  accepted conversion count (wraps)
//   busy, err, err_code       activity, error state, error cause
// ============================================================================
module host_console #(
  parameter int TIMEOUT = 1000000,
  parameter int TW      = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        run,
  input  logic [3:0]  cfg_didx,
  input  logic [3:0]  cfg_freq,
  output logic        fs_com_send,
  input  logic        fd_com_send,
  output logic [3:0]  send_btype,
  output logic [3:0]  send_param,
  input  logic        fs_com_read,
  output logic        fd_com_read,
  input  logic [3:0]  read_btype,
  input  logic [7:0]  read_type,
  input  logic [7:0]  read_temp,
  input  logic [3:0]  read_stat,
  output logic        link_ok,
  output logic [7:0]  dev_type,
  output logic [7:0]  dev_temp,
  output logic [3:0]  dev_stat,
  output logic        data_vld,
  output logic [15:0] conv_cnt,
  output logic        busy,
  output logic        err,
  output logic [1:0]  err_code
);

  localparam logic [3:0] c_BAG_INIT   = 4'b0000;
  localparam logic [3:0] c_BAG_DIDX   = 4'b0101;
  localparam logic [3:0] c_BAG_DPARAM = 4'b0110;
  localparam logic [3:0] c_BAG_DDIDX  = 4'b0111;
  localparam logic [3:0] c_BAG_DLINK  = 4'b1000;
  localparam logic [3:0] c_BAG_DTYPE  = 4'b1001;
  localparam logic [3:0] c_BAG_DTEMP  = 4'b1010;
  localparam logic [3:0] c_BAG_DATA0  = 4'b1101;

  localparam logic [1:0] c_ERR_NONE    = 2'b00;
  localparam logic [1:0] c_ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] c_ERR_BTYPE   = 2'b10;

  localparam logic [TW-1:0] c_TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_LINK_WAIT = 4'd1,
    S_LINK_ACK  = 4'd2,
    S_TYPE_SEND = 4'd3,
    S_TYPE_WAIT = 4'd4,
    S_TYPE_ACK  = 4'd5,
    S_CONF_SEND = 4'd6,
    S_CONF_WAIT = 4'd7,
    S_CONF_ACK  = 4'd8,
    S_RUN_IDLE  = 4'd9,
    S_CONV_SEND = 4'd10,
    S_CONV_WAIT = 4'd11,
    S_CONV_ACK  = 4'd12,
    S_ERR       = 4'd13
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tcnt_q;
  logic [3:0]    cfg_didx_q, cfg_freq_q;
  logic [3:0]    sh_btype_q, sh_stat_q;
  logic [7:0]    sh_type_q, sh_temp_q;
  logic          link_ok_q;
  logic [7:0]    dev_type_q, dev_temp_q;
  logic [3:0]    dev_stat_q, ddidx_q;
  logic          data_vld_q;
  logic [15:0]   conv_cnt_q;
  logic [1:0]    err_code_q, err_code_d;

  // Control strobes decoded alongside the next state.
  logic w_latch_cfg, w_capture, w_set_link;
  logic w_commit_type, w_commit_temp, w_commit_conv;
  logic w_timed, w_tmo;

  assign w_tmo = (tcnt_q == c_TMO_LAST);

  // --------------------------------------------------------------------------
  // Next-state and output decode. In every *_SEND / *_WAIT state the
  // handshake event is tested before the timeout so that it wins a tie.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    err_code_d    = err_code_q;
    w_latch_cfg   = 1'b0;
    w_capture     = 1'b0;
    w_set_link    = 1'b0;
    w_commit_type = 1'b0;
    w_commit_temp = 1'b0;
    w_commit_conv = 1'b0;
    w_timed       = 1'b0;
    fs_com_send   = 1'b0;
    fd_com_read   = 1'b0;
    send_btype    = c_BAG_INIT;
    send_param    = 4'd0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          w_latch_cfg = 1'b1;
          state_d     = S_LINK_WAIT;
        end
      end

      S_LINK_WAIT, S_TYPE_WAIT, S_CONF_WAIT, S_CONV_WAIT: begin
        w_timed = 1'b1;
        if (fs_com_read) begin
          w_capture = 1'b1;
          case (state_q)
            S_LINK_WAIT: state_d = S_LINK_ACK;
            S_TYPE_WAIT: state_d = S_TYPE_ACK;
            S_CONF_WAIT: state_d = S_CONF_ACK;
            default:     state_d = S_CONV_ACK;
          endcase
        end else if (w_tmo) begin
          state_d    = S_ERR;
          err_code_d = c_ERR_TIMEOUT;
        end
      end

      S_TYPE_SEND, S_CONF_SEND, S_CONV_SEND: begin
        w_timed     = 1'b1;
        fs_com_send = 1'b1;
        case (state_q)
          S_TYPE_SEND: begin
            send_btype = c_BAG_DIDX;
            send_param = cfg_didx_q;
          end
          S_CONF_SEND: begin
            send_btype = c_BAG_DPARAM;
            send_param = cfg_freq_q;
          end
          default: begin
            send_btype = c_BAG_DDIDX;
            send_param = ddidx_q;
          end
        endcase
        if (fd_com_send) begin
          case (state_q)
            S_TYPE_SEND: state_d = S_TYPE_WAIT;
            S_CONF_SEND: state_d = S_CONF_WAIT;
            default:     state_d = S_CONV_WAIT;
          endcase
        end else if (w_tmo) begin
          state_d    = S_ERR;
          err_code_d = c_ERR_TIMEOUT;
        end
      end

      // ACK states: hold the acknowledge until the receiver releases, then
      // judge the packet type captured on entry.
      S_LINK_ACK: begin
        fd_com_read = 1'b1;
        if (!fs_com_read) begin
          if (sh_btype_q == c_BAG_DLINK) begin
            w_set_link = 1'b1;
            state_d    = S_TYPE_SEND;
          end else begin
            state_d    = S_ERR;
            err_code_d = c_ERR_BTYPE;
          end
        end
      end

      S_TYPE_ACK: begin
        fd_com_read = 1'b1;
        if (!fs_com_read) begin
          if (sh_btype_q == c_BAG_DTYPE) begin
            w_commit_type = 1'b1;
            state_d       = S_CONF_SEND;
          end else begin
            state_d    = S_ERR;
            err_code_d = c_ERR_BTYPE;
          end
        end
      end

      S_CONF_ACK: begin
        fd_com_read = 1'b1;
        if (!fs_com_read) begin
          if (sh_btype_q == c_BAG_DTEMP) begin
            w_commit_temp = 1'b1;
            state_d       = S_RUN_IDLE;
          end else begin
            state_d    = S_ERR;
            err_code_d = c_ERR_BTYPE;
          end
        end
      end

      S_CONV_ACK: begin
        fd_com_read = 1'b1;
        if (!fs_com_read) begin
          if (sh_btype_q == c_BAG_DATA0) begin
            w_commit_conv = 1'b1;
            state_d       = S_RUN_IDLE;
          end else begin
            state_d    = S_ERR;
            err_code_d = c_ERR_BTYPE;
          end
        end
      end

      S_RUN_IDLE: begin
        if (run) begin
          state_d = S_CONV_SEND;
        end
      end

      S_ERR: begin
        if (start) begin
          w_latch_cfg = 1'b1;
          err_code_d  = c_ERR_NONE;
          state_d     = link_ok_q ? S_TYPE_SEND : S_LINK_WAIT;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Timeout counter: restarts on every state change, counts only in timed
  // states so it is always zero when a timed state is entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt_q <= '0;
    end else if (state_d != state_q || !w_timed) begin
      tcnt_q <= '0;
    end else begin
      tcnt_q <= tcnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_didx_q <= 4'd0;
      cfg_freq_q <= 4'd0;
      sh_btype_q <= 4'd0;
      sh_type_q  <= 8'd0;
      sh_temp_q  <= 8'd0;
      sh_stat_q  <= 4'd0;
      link_ok_q  <= 1'b0;
      dev_type_q <= 8'd0;
      dev_temp_q <= 8'd0;
      dev_stat_q <= 4'd0;
      ddidx_q    <= 4'd0;
      data_vld_q <= 1'b0;
      conv_cnt_q <= 16'd0;
      err_code_q <= c_ERR_NONE;
    end else begin
      err_code_q <= err_code_d;
      data_vld_q <= w_commit_conv;
      if (w_latch_cfg) begin
        cfg_didx_q <= cfg_didx;
        cfg_freq_q <= cfg_freq;
      end
      if (w_capture) begin
        sh_btype_q <= read_btype;
        sh_type_q  <= read_type;
        sh_temp_q  <= read_temp;
        sh_stat_q  <= read_stat;
      end
      if (w_set_link) begin
        link_ok_q <= 1'b1;
      end
      if (w_commit_type) begin
        dev_type_q <= sh_type_q;
      end
      if (w_commit_temp) begin
        dev_temp_q <= sh_temp_q;
      end
      if (w_commit_conv) begin
        dev_stat_q <= sh_stat_q;
        conv_cnt_q <= conv_cnt_q + 16'd1;
        ddidx_q    <= ddidx_q + 4'd1;
      end
    end
  end

  assign link_ok  = link_ok_q;
  assign dev_type = dev_type_q;
  assign dev_temp = dev_temp_q;
  assign dev_stat = dev_stat_q;
  assign data_vld = data_vld_q;
  assign conv_cnt = conv_cnt_q;
  assign err_code = err_code_q;
  assign err      = (state_q == S_ERR);
  assign busy     = (state_q != S_IDLE) && (state_q != S_RUN_IDLE) && (state_q != S_ERR);

endmodule
`default_nettype wire

// File: tb/tb_host_console.sv
`default_nettype none
// ============================================================================
// Module   : tb_host_console
// Purpose  : Randomized scoreboard bench for host_console. The stimulus
//            process plays the host controller and the link responder; it
//            pushes expected packets, conversion reports and error reports
//            into queues that independent monitors pop when the DUT presents
//            them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_host_console;

  localparam int TIMEOUT = 16;
  localparam int TW      = 20;

  localparam logic [3:0] BAG_DIDX   = 4'b0101;
  localparam logic [3:0] BAG_DPARAM = 4'b0110;
  localparam logic [3:0] BAG_DDIDX  = 4'b0111;
  localparam logic [3:0] BAG_DLINK  = 4'b1000;
  localparam logic [3:0] BAG_DTYPE  = 4'b1001;
  localparam logic [3:0] BAG_DTEMP  = 4'b1010;
  localparam logic [3:0] BAG_DATA0  = 4'b1101;

  logic        clk, rst, start, run;
  logic [3:0]  cfg_didx, cfg_freq;
  logic        fs_com_send, fd_com_send;
  logic [3:0]  send_btype, send_param;
  logic        fs_com_read, fd_com_read;
  logic [3:0]  read_btype, read_stat;
  logic [7:0]  read_type, read_temp;
  logic        link_ok, data_vld, busy, err;
  logic [7:0]  dev_type, dev_temp;
  logic [3:0]  dev_stat;
  logic [15:0] conv_cnt;
  logic [1:0]  err_code;

  host_console #(.TIMEOUT(TIMEOUT), .TW(TW)) dut (
    .clk(clk), .rst(rst), .start(start), .run(run),
    .cfg_didx(cfg_didx), .cfg_freq(cfg_freq),
    .fs_com_send(fs_com_send), .fd_com_send(fd_com_send),
    .send_btype(send_btype), .send_param(send_param),
    .fs_com_read(fs_com_read), .fd_com_read(fd_com_read),
    .read_btype(read_btype), .read_type(read_type),
    .read_temp(read_temp), .read_stat(read_stat),
    .link_ok(link_ok), .dev_type(dev_type), .dev_temp(dev_temp),
    .dev_stat(dev_stat), .data_vld(data_vld), .conv_cnt(conv_cnt),
    .busy(busy), .err(err), .err_code(err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct packed { logic [3:0] bt; logic [3:0] pr; } snd_t;
  typedef struct packed { logic [3:0] st; logic [15:0] cnt; } dat_t;
  typedef struct packed { logic [1:0] code; logic [7:0] dtype; } err_t;

  snd_t exp_snd[$];
  dat_t exp_dat[$];
  err_t exp_err[$];

  // ------------------------------------------------------------ monitors --
  initial begin : mon_send
    logic prev;
    snd_t cur;
    prev = 1'b0;
    cur  = '0;
    forever begin
      @(negedge clk);
      if (fs_com_send && !prev) begin
        if (exp_snd.size() == 0) begin
          chk("send_unexpected", 32'(fs_com_send), 32'd0);
        end else begin
          cur = exp_snd.pop_front();
          chk("send_btype", 32'(send_btype), 32'(cur.bt));
          chk("send_param", 32'(send_param), 32'(cur.pr));
        end
      end else if (fs_com_send) begin
        chk("send_stable", 32'({send_btype, send_param}), 32'(cur));
      end else begin
        chk("send_idle_zero", 32'({send_btype, send_param}), 32'd0);
      end
      prev = fs_com_send;
    end
  end

  initial begin : mon_data
    dat_t e;
    forever begin
      @(negedge clk);
      if (data_vld) begin
        if (exp_dat.size() == 0) begin
          chk("data_unexpected", 32'(data_vld), 32'd0);
        end else begin
          e = exp_dat.pop_front();
          chk("dev_stat", 32'(dev_stat), 32'(e.st));
          chk("conv_cnt", 32'(conv_cnt), 32'(e.cnt));
        end
      end
    end
  end

  initial begin : mon_err
    logic prev;
    err_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (err && !prev) begin
        if (exp_err.size() == 0) begin
          chk("err_unexpected", 32'(err), 32'd0);
        end else begin
          e = exp_err.pop_front();
          chk("err_code", 32'(err_code), 32'(e.code));
          chk("err_dev_type", 32'(dev_type), 32'(e.dtype));
        end
      end
      prev = err;
    end
  end

  // ------------------------------------------------------------- drivers --
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_send();
    int n = 0;
    while (!fs_com_send && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("send_req", 32'(fs_com_send), 32'd1);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    fd_com_send = 1'b1;
    @(negedge clk);
    fd_com_send = 1'b0;
    chk("send_release", 32'(fs_com_send), 32'd0);
  endtask

  task automatic scramble();
    read_btype = 4'($urandom);
    read_type  = 8'($urandom);
    read_temp  = 8'($urandom);
    read_stat  = 4'($urandom);
  endtask

  // Payload is scrambled while the packet is held and after release, so only
  // the values present on the capture edge may reach the outputs.
  task automatic do_reply(input logic [3:0] bt, input logic [7:0] ty,
                          input logic [7:0] tp, input logic [3:0] st);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    fs_com_read = 1'b1;
    read_btype  = bt;
    read_type   = ty;
    read_temp   = tp;
    read_stat   = st;
    @(negedge clk);
    chk("ack_hold", 32'(fd_com_read), 32'd1);
    repeat ($urandom_range(0, 2)) begin
      scramble();
      @(negedge clk);
      chk("ack_hold", 32'(fd_com_read), 32'd1);
    end
    fs_com_read = 1'b0;
    scramble();
    @(negedge clk);
    chk("ack_release", 32'(fd_com_read), 32'd0);
  endtask

  task automatic wait_timeout(input string nm);
    int cyc = 0;
    while (!err && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk(nm, 32'(cyc), 32'(TIMEOUT));
    chk("timeout_code", 32'(err_code), 32'd1);
  endtask

  // --------------------------------------------------------------- model --
  logic [7:0] m_type, m_temp, t8;
  logic [3:0] m_didx, m_freq, m_stat;
  int         m_conv;

  initial begin : stim
    rst = 1'b1; start = 1'b0; run = 1'b0;
    cfg_didx = 4'd0; cfg_freq = 4'd0;
    fd_com_send = 1'b0; fs_com_read = 1'b0;
    read_btype = 4'd0; read_type = 8'd0; read_temp = 8'd0; read_stat = 4'd0;
    m_conv = 0; m_stat = 4'd0; m_type = 8'd0; m_temp = 8'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'({err, err_code}), 32'd0);
    chk("rst_link", 32'(link_ok), 32'd0);
    chk("rst_cnt", 32'(conv_cnt), 32'd0);
    chk("rst_hs", 32'({fs_com_send, fd_com_read, data_vld}), 32'd0);
    chk("rst_dev", 32'({dev_type, dev_temp, dev_stat}), 32'd0);

    // Nominal bring-up
    m_didx = 4'd3; m_freq = 4'd5;
    cfg_didx = m_didx; cfg_freq = m_freq;
    exp_snd.push_back('{BAG_DIDX, m_didx});
    exp_snd.push_back('{BAG_DPARAM, m_freq});
    pulse_start();
    chk("busy_after_start", 32'(busy), 32'd1);
    cfg_didx = 4'($urandom); cfg_freq = 4'($urandom);
    do_reply(BAG_DLINK, 8'($urandom), 8'($urandom), 4'($urandom));
    chk("link_ok", 32'(link_ok), 32'd1);
    do_send();
    m_type = 8'h42;
    do_reply(BAG_DTYPE, m_type, 8'($urandom), 4'($urandom));
    do_send();
    m_temp = 8'h19;
    do_reply(BAG_DTEMP, 8'($urandom), m_temp, 4'($urandom));
    chk("dev_type", 32'(dev_type), 32'(m_type));
    chk("dev_temp", 32'(dev_temp), 32'(m_temp));
    chk("bringup_idle", 32'({busy, err}), 32'd0);

    // Back-to-back conversions; run drops during the last one
    run = 1'b1;
    for (int i = 0; i < 18; i++) begin
      exp_snd.push_back('{BAG_DDIDX, 4'(m_conv % 16)});
      do_send();
      if (i == 17) run = 1'b0;
      m_stat = 4'($urandom);
      m_conv++;
      exp_dat.push_back('{m_stat, 16'(m_conv % 65536)});
      do_reply(BAG_DATA0, 8'($urandom), 8'($urandom), m_stat);
    end
    repeat (5) @(negedge clk);
    chk("conv_stop_busy", 32'(busy), 32'd0);
    chk("conv_stop_send", 32'(fs_com_send), 32'd0);
    chk("conv_total", 32'(conv_cnt), 32'(m_conv));
    chk("conv_stat", 32'(dev_stat), 32'(m_stat));

    // Conversion with no reply -> timeout in CONV_WAIT
    run = 1'b1;
    exp_snd.push_back('{BAG_DDIDX, 4'(m_conv % 16)});
    exp_err.push_back('{2'b01, m_type});
    do_send();
    run = 1'b0;
    wait_timeout("conv_timeout_cycles");
    chk("conv_cnt_after_tmo", 32'(conv_cnt), 32'(m_conv));

    // Retry from ERR with link up -> DIDX resent, then timeout in TYPE_WAIT
    m_didx = 4'($urandom);
    cfg_didx = m_didx;
    exp_snd.push_back('{BAG_DIDX, m_didx});
    exp_err.push_back('{2'b01, m_type});
    pulse_start();
    chk("retry_clears_err", 32'({err, err_code}), 32'd0);
    chk("retry_link_kept", 32'(link_ok), 32'd1);
    do_send();
    wait_timeout("type_timeout_cycles");
    chk("tmo_link_kept", 32'(link_ok), 32'd1);

    // Wrong reply type in TYPE_WAIT
    m_didx = 4'($urandom);
    cfg_didx = m_didx;
    exp_snd.push_back('{BAG_DIDX, m_didx});
    exp_err.push_back('{2'b10, m_type});
    pulse_start();
    do_send();
    do_reply(BAG_DTEMP, 8'($urandom), 8'($urandom), 4'($urandom));
    chk("btype_err", 32'({err, err_code}), 32'({1'b1, 2'b10}));
    chk("btype_dev_type", 32'(dev_type), 32'(m_type));

    // Fresh retry, then reset while CONF_SEND is waiting for the transmitter
    m_didx = 4'($urandom); m_freq = 4'($urandom);
    cfg_didx = m_didx; cfg_freq = m_freq;
    exp_snd.push_back('{BAG_DIDX, m_didx});
    exp_snd.push_back('{BAG_DPARAM, m_freq});
    pulse_start();
    do_send();
    t8 = 8'($urandom);
    m_type = t8;
    do_reply(BAG_DTYPE, m_type, 8'($urandom), 4'($urandom));
    chk("retry_dev_type", 32'(dev_type), 32'(m_type));
    repeat (2) @(negedge clk);
    chk("conf_send_pending", 32'(fs_com_send), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_send", 32'(fs_com_send), 32'd0);
    chk("rst_mid_link", 32'(link_ok), 32'd0);
    chk("rst_mid_cnt", 32'(conv_cnt), 32'd0);
    chk("rst_mid_busy", 32'({busy, err}), 32'd0);
    repeat (10) @(negedge clk);
    chk("rst_needs_start", 32'({busy, fs_com_send}), 32'd0);

    @(negedge clk);
    chk("snd_queue_left", 32'(exp_snd.size()), 32'd0);
    chk("dat_queue_left", 32'(exp_dat.size()), 32'd0);
    chk("err_queue_left", 32'(exp_err.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
